// File: rtl/vdb_vga_tx.sv
// VGA timing source for the devboard monitor: parameterised sync generation with a valid/ready pixel feed.
// Optional build macro VDB_VGA_TX_TEST_PATTERN_EN: underrun slots show an 8-bar colour pattern instead of black.
module vdb_vga_tx #(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pix_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       pix_ready,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       active_video,
    output logic       sof,
    output logic       underrun,
    input  logic       underrun_clr
);

    localparam int H_TOT = HOR_SYNC + HOR_BP + HOR_ACT + HOR_FP;
    localparam int V_TOT = VERT_SYNC + VERT_BP + VERT_ACT + VERT_FP;

    if (H_TOT > 2048 || V_TOT > 1024) begin : g_size_check
        $error("vdb_vga_tx: H_TOT must not exceed 2048 and V_TOT must not exceed 1024");
    end

    localparam logic [10:0] H_SYNC_END = 11'(HOR_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(HOR_SYNC + HOR_BP);
    localparam logic [10:0] H_ACT_END  = 11'(HOR_SYNC + HOR_BP + HOR_ACT);
    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [9:0]  V_SYNC_END = 10'(VERT_SYNC);
    localparam logic [9:0]  V_ACT_BEG  = 10'(VERT_SYNC + VERT_BP);
    localparam logic [9:0]  V_ACT_END  = 10'(VERT_SYNC + VERT_BP + VERT_ACT);
    localparam logic [9:0]  V_LAST     = 10'(V_TOT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] h_cnt, h_d;
    logic [9:0]  v_cnt, v_d;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            state_q <= state_d;
            h_cnt   <= h_d;
            v_cnt   <= v_d;
        end
    end

    // enable is only honoured on the last pixel of a frame, so a frame always completes
    always_comb begin
        state_d = state_q;
        h_d     = h_cnt;
        v_d     = v_cnt;
        case (state_q)
            IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_d = '0;
                    if (v_cnt == V_LAST) begin
                        v_d = '0;
                        if (!enable) state_d = IDLE;
                    end else begin
                        v_d = v_cnt + 10'd1;
                    end
                end else begin
                    h_d = h_cnt + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic run, hs_n, vs_n, h_act, v_act, frame_start, underrun_slot;

    always_comb begin
        run           = (state_q == RUN);
        hs_n          = !run || (h_cnt >= H_SYNC_END);
        vs_n          = !run || (v_cnt >= V_SYNC_END);
        h_act         = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
        v_act         = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        pix_ready     = run && h_act && v_act;
        frame_start   = run && (h_cnt == '0) && (v_cnt == '0);
        underrun_slot = pix_ready && !pix_valid;
    end

    logic [7:0] fill_r, fill_g, fill_b;

`ifdef VDB_VGA_TX_TEST_PATTERN_EN
    localparam int BAR_SHIFT = ($clog2(HOR_ACT) > 3) ? ($clog2(HOR_ACT) - 3) : 0;

    logic [10:0] act_idx;
    logic [2:0]  bar;

    // bar colour bits: red in bars 0,1,4,5; green in 0..3; blue in even bars
    always_comb begin
        act_idx = h_cnt - H_ACT_BEG;
        bar     = 3'(act_idx >> BAR_SHIFT);
        fill_r  = pix_valid ? pix_r : {8{~bar[1]}};
        fill_g  = pix_valid ? pix_g : {8{~bar[2]}};
        fill_b  = pix_valid ? pix_b : {8{~bar[0]}};
    end
`else
    always_comb begin
        fill_r = pix_valid ? pix_r : '0;
        fill_g = pix_valid ? pix_g : '0;
        fill_b = pix_valid ? pix_b : '0;
    end
`endif

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            active_video <= 1'b0;
            sof          <= 1'b0;
            r            <= '0;
            g            <= '0;
            b            <= '0;
            underrun     <= 1'b0;
        end else begin
            hsync        <= hs_n;
            vsync        <= vs_n;
            active_video <= pix_ready;
            sof          <= frame_start;
            r            <= pix_ready ? fill_r : '0;
            g            <= pix_ready ? fill_g : '0;
            b            <= pix_ready ? fill_b : '0;
            if (underrun_slot) underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vdb_vga_tx.sv
// Scoreboard bench for vdb_vga_tx with a reduced timing set (25 x 11 frame).
module tb_vdb_vga_tx;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = 25, VT = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
    logic       underrun_clr = 1'b0;
    logic       pix_ready;
    logic [7:0] r, g, b;
    logic       hsync, vsync, active_video, sof, underrun;

    vdb_vga_tx #(
        .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
        .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB)
    ) dut (
        .pixel_clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_ready(pix_ready),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .active_video(active_video), .sof(sof), .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // {hsync, vsync, active_video, sof, underrun, pix_ready, r, g, b}
    logic [29:0] sb[$];

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic bit slot(input bit run, input int h, input int v);
        return run && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
    endfunction

    // Predictor: reference timing model fed by the inputs the DUT sampled on this edge
    bit m_run = 0, m_ur = 0;
    int m_h = 0, m_v = 0;
    initial begin : predictor
        bit hs, vs, act, sf, rdy;
        logic [23:0] rgb;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_run = 0; m_h = 0; m_v = 0; m_ur = 0;
                hs = 1; vs = 1; act = 0; sf = 0; rgb = '0;
            end else begin
                act = slot(m_run, m_h, m_v);
                hs  = !(m_run && m_h < HS);
                vs  = !(m_run && m_v < VS);
                sf  = m_run && m_h == 0 && m_v == 0;
                rgb = '0;
                if (act && pix_valid) rgb = {pix_r, pix_g, pix_b};
`ifdef VDB_VGA_TX_TEST_PATTERN_EN
                else if (act) rgb = bar_colour(((m_h - (HS + HB)) / 2) % 8);
`endif
                if (act && !pix_valid) m_ur = 1;
                else if (underrun_clr) m_ur = 0;
                if (!m_run) begin
                    if (enable) m_run = 1;
                end else if (m_h == HT - 1) begin
                    m_h = 0;
                    if (m_v == VT - 1) begin
                        m_v = 0;
                        if (!enable) m_run = 0;
                    end else m_v++;
                end else m_h++;
            end
            rdy = slot(m_run, m_h, m_v);
            sb.push_back({hs, vs, act, sf, m_ur, rdy, rgb});
        end
    end

    // Monitor: pops one expected output per cycle and tracks line-level timing
    int cyc = 0, sof_cnt = 0, hs_fall_cyc = 0, line_act = 0;
    bit prev_hs = 1, prev_act = 0;
    initial begin : monitor
        logic [29:0] exp_v;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (sb.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                exp_v = sb.pop_front();
                check("cycle_out", {2'b0, hsync, vsync, active_video, sof, underrun, pix_ready, r, g, b},
                      {2'b0, exp_v});
            end
            if (!rst_n) begin
                line_act = 0; prev_hs = 1; prev_act = 0;
            end else begin
                if (sof) sof_cnt++;
                if (prev_hs && !hsync) begin
                    if (line_act != 0) check("act_per_line", line_act, HA);
                    line_act = 0;
                    hs_fall_cyc = cyc;
                end
                if (active_video && !prev_act) check("act_after_hs_fall", cyc - hs_fall_cyc, HS + HB);
                if (active_video) line_act++;
                prev_hs = hsync;
                prev_act = active_video;
            end
        end
    end

    // Stream source: beat data advances only after the previous beat was accepted
    bit took = 0;
    logic [7:0] beat = 8'h01;
    task automatic step(input bit valid, input bit clr);
        @(negedge clk);
        if (took) beat = beat + 8'd1;
        pix_r = beat;
        pix_g = ~beat;
        pix_b = beat ^ 8'h5A;
        pix_valid = valid;
        underrun_clr = clr;
        took = valid && pix_ready;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int i;
        repeat (3) step(0, 0);
        rst_n = 1'b1;
        repeat (2000) step(0, 0);
        check("idle_sof_count", sof_cnt, 0);
        check("idle_hsync", hsync, 1);

        enable = 1'b1;
        repeat (2 * HT * VT) step(1, 0);
        check("sof_two_frames", sof_cnt, 2);
        check("no_underrun", underrun, 0);

        for (i = 0; i < 400 && !pix_ready; i++) step(1, 0);
        check("wait_active", pix_ready, 1);
        step(1, 0);
        step(1, 0);
        repeat (5) step(0, 0);
        step(1, 0);
        repeat (3) step(1, 0);
        check("underrun_sticky", underrun, 1);
        for (i = 0; i < 400 && pix_ready; i++) step(1, 0);
        step(1, 1);
        step(1, 0);
        check("underrun_cleared", underrun, 0);
        for (i = 0; i < 400 && !pix_ready; i++) step(1, 0);
        step(0, 1);
        step(1, 0);
        check("underrun_set_wins", underrun, 1);
        for (i = 0; i < 400 && pix_ready; i++) step(1, 0);
        step(1, 1);
        step(1, 0);

        for (i = 0; i < 600 && !sof; i++) step(1, 0);
        check("wait_sof", sof, 1);
        repeat (5 * HT + 3) step(1, 0);
        enable = 1'b0;
        repeat (400) step(1, 0);
        check("idle_after_disable", {hsync, vsync, active_video}, 3'b110);

        enable = 1'b1;
        @(posedge clk);
        #2;
        check("reenable_no_sof_yet", sof, 0);
        @(posedge clk);
        #2;
        check("reenable_sof", sof, 1);
        check("reenable_hsync_low", hsync, 0);
        repeat (120) step(1, 0);

        for (i = 0; i < 400 && !active_video; i++) step(1, 0);
        check("wait_active_video", active_video, 1);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("async_rst_syncs", {hsync, vsync}, 2'b11);
        check("async_rst_rgb", {r, g, b}, 24'h0);
        check("async_rst_act_ready", {active_video, pix_ready, sof}, 3'b000);
        step(1, 0);
        step(1, 0);
        rst_n = 1'b1;
        repeat (30) step(1, 0);
        check("idle_after_reset", {hsync, vsync, active_video, pix_ready}, 4'b1100);

        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
